// File: rtl/rx_descramble_pn_gen.sv
// rtl/rx_descramble_pn_gen.sv - receive-side PN generator and frame sequencer
`timescale 1ns/1ps
module rx_descramble_pn_gen #(
    parameter int                HDR_WORDS = 16,
    parameter int                BLK_WORDS = 93,
    parameter int                LFSR_W    = 15,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 15'h6000
) (
    input  logic              logic_clk_in,
    input  logic              logic_rst_in,
    input  logic              frame_start_in,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic [7:0]        blk_num_in,
    input  logic              data_pulse_in,
    input  logic [31:0]       data_in,
    output logic              data_pulse_out,
    output logic [31:0]       data_out,
    output logic [31:0]       pn_out,
    output logic              header_flag_out,
    output logic              frame_done_out,
    output logic              overrun_flag_out
);

    localparam int MAX_WORDS = (HDR_WORDS > BLK_WORDS) ? HDR_WORDS : BLK_WORDS;
    localparam int WCW       = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [WCW-1:0] HDR_LAST = WCW'(HDR_WORDS - 1);
    localparam logic [WCW-1:0] BLK_LAST = WCW'(BLK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, HEADER, DATA, DONE} state_t;

    state_t            state;
    logic [WCW-1:0]    word_cnt;
    logic [7:0]        blk_cnt;
    logic [7:0]        n_lat;
    logic [LFSR_W-1:0] lfsr;

    state_t            cur_state;
    logic [WCW-1:0]    cur_word;
    logic [7:0]        cur_blk;
    logic [7:0]        cur_n;
    logic [LFSR_W-1:0] cur_lfsr;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic [31:0]       pn_nxt;

    // 32 Fibonacci steps unrolled; the first generated bit lands in bit 31.
    function automatic logic [LFSR_W+31:0] pn_step(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] st;
        logic [31:0]       pn;
        logic              fb;
        st = s;
        pn = '0;
        for (int k = 0; k < 32; k++) begin
            fb        = ^(st & LFSR_TAPS);
            pn[31-k]  = fb;
            st        = {st[LFSR_W-2:0], fb};
        end
        return {st, pn};
    endfunction

    // A frame start overrides the current context in the same cycle, so a
    // coinciding pulse is handled as header word 0 of the new frame.
    always_comb begin
        cur_state = state;
        cur_word  = word_cnt;
        cur_blk   = blk_cnt;
        cur_n     = n_lat;
        cur_lfsr  = lfsr;
        if (frame_start_in) begin
            cur_state = HEADER;
            cur_word  = '0;
            cur_blk   = '0;
            cur_n     = blk_num_in;
            cur_lfsr  = (seed_in == '0) ? LFSR_W'(1) : seed_in;
        end
        {lfsr_nxt, pn_nxt} = pn_step(cur_lfsr);
    end

    always_ff @(posedge logic_clk_in or negedge logic_rst_in) begin
        if (!logic_rst_in) begin
            state            <= IDLE;
            word_cnt         <= '0;
            blk_cnt          <= '0;
            n_lat            <= '0;
            lfsr             <= '0;
            data_pulse_out   <= 1'b0;
            data_out         <= '0;
            pn_out           <= '0;
            header_flag_out  <= 1'b0;
            frame_done_out   <= 1'b0;
            overrun_flag_out <= 1'b0;
        end else begin
            data_pulse_out <= 1'b0;
            frame_done_out <= 1'b0;

            if (frame_start_in) begin
                state            <= HEADER;
                word_cnt         <= '0;
                blk_cnt          <= '0;
                n_lat            <= cur_n;
                lfsr             <= cur_lfsr;
                overrun_flag_out <= 1'b0;
            end

            if (data_pulse_in) begin
                case (cur_state)
                    HEADER: begin
                        data_pulse_out  <= 1'b1;
                        data_out        <= data_in;
                        pn_out          <= '0;
                        header_flag_out <= 1'b1;
                        if (cur_word == HDR_LAST) begin
                            word_cnt <= '0;
                            if (cur_n == 8'd0) begin
                                state          <= DONE;
                                frame_done_out <= 1'b1;
                            end else begin
                                state <= DATA;
                            end
                        end else begin
                            word_cnt <= cur_word + 1'b1;
                        end
                    end
                    DATA: begin
                        data_pulse_out  <= 1'b1;
                        data_out        <= data_in;
                        pn_out          <= pn_nxt;
                        header_flag_out <= 1'b0;
                        lfsr            <= lfsr_nxt;
                        if (cur_word == BLK_LAST) begin
                            word_cnt <= '0;
                            blk_cnt  <= cur_blk + 8'd1;
                            if (cur_blk + 8'd1 == cur_n) begin
                                state          <= DONE;
                                frame_done_out <= 1'b1;
                            end
                        end else begin
                            word_cnt <= cur_word + 1'b1;
                        end
                    end
                    default: overrun_flag_out <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_descramble_pn_gen.sv
// tb/tb_rx_descramble_pn_gen.sv - directed self-checking bench for rx_descramble_pn_gen
`timescale 1ns/1ps
module tb_rx_descramble_pn_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [14:0] seed = '0;
    logic [7:0]  blk_num = '0;
    logic        pulse = 1'b0;
    logic [31:0] din = '0;
    logic        pulse_o;
    logic [31:0] data_o;
    logic [31:0] pn_o;
    logic        hdr_o;
    logic        done_o;
    logic        ovr_o;

    always #2.5 clk = ~clk;

    rx_descramble_pn_gen dut (
        .logic_clk_in     (clk),
        .logic_rst_in     (rst_n),
        .frame_start_in   (frame_start),
        .seed_in          (seed),
        .blk_num_in       (blk_num),
        .data_pulse_in    (pulse),
        .data_in          (din),
        .data_pulse_out   (pulse_o),
        .data_out         (data_o),
        .pn_out           (pn_o),
        .header_flag_out  (hdr_o),
        .frame_done_out   (done_o),
        .overrun_flag_out (ovr_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int          m_state, m_word, m_blk, m_n;
    logic [14:0] m_lfsr;
    logic        m_ovr;
    logic        exp_pulse, exp_hdr, exp_done;
    logic [31:0] exp_data, exp_pn;

    int          out_cnt, done_at;
    logic [31:0] cap_pn17;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_state = 0; m_word = 0; m_blk = 0; m_n = 0; m_lfsr = '0; m_ovr = 1'b0;
        exp_pulse = 1'b0; exp_hdr = 1'b0; exp_done = 1'b0;
        exp_data = '0; exp_pn = '0;
    endtask

    task automatic chk_outs();
        chk("pulse", pulse_o, exp_pulse);
        chk("data",  data_o,  exp_data);
        chk("pn",    pn_o,    exp_pn);
        chk("hdr",   hdr_o,   exp_hdr);
        chk("done",  done_o,  exp_done);
        chk("ovr",   ovr_o,   m_ovr);
        if (pulse_o) begin
            out_cnt++;
            if (out_cnt == 17) cap_pn17 = pn_o;
            if (done_o) done_at = out_cnt;
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        frame_start = 1'b0;
        pulse = 1'b0;
        model_clear();
        repeat (cycles) begin
            @(negedge clk);
            chk_outs();
        end
        rst_n = 1'b1;
    endtask

    // One clock: check what the previous inputs produced, then apply new ones.
    task automatic cyc(input logic fs, input logic [14:0] sd, input logic [7:0] n,
                       input logic p, input logic [31:0] d);
        logic fb;
        @(negedge clk);
        chk_outs();
        frame_start = fs; seed = sd; blk_num = n; pulse = p; din = d;
        exp_pulse = 1'b0;
        exp_done  = 1'b0;
        if (fs) begin
            m_lfsr = (sd == 15'd0) ? 15'd1 : sd;
            m_n = int'(n); m_word = 0; m_blk = 0; m_state = 1; m_ovr = 1'b0;
            out_cnt = 0; done_at = 0; cap_pn17 = '0;
        end
        if (p) begin
            case (m_state)
                1: begin
                    exp_pulse = 1'b1; exp_data = d; exp_pn = '0; exp_hdr = 1'b1;
                    m_word++;
                    if (m_word == 16) begin
                        m_word = 0;
                        if (m_n == 0) begin m_state = 3; exp_done = 1'b1; end
                        else m_state = 2;
                    end
                end
                2: begin
                    exp_pulse = 1'b1; exp_data = d; exp_hdr = 1'b0;
                    for (int k = 0; k < 32; k++) begin
                        fb = m_lfsr[14] ^ m_lfsr[13];
                        exp_pn = {exp_pn[30:0], fb};
                        m_lfsr = {m_lfsr[13:0], fb};
                    end
                    m_word++;
                    if (m_word == 93) begin
                        m_word = 0;
                        m_blk++;
                        if (m_blk == m_n) begin m_state = 3; exp_done = 1'b1; end
                    end
                end
                default: m_ovr = 1'b1;
            endcase
        end
    endtask

    initial begin
        model_clear();
        out_cnt = 0; done_at = 0; cap_pn17 = '0;

        // Reset state, then a pulse while IDLE
        do_reset(2);
        cyc(0, 0, 0, 1, 32'hdead_beef);
        repeat (3) cyc(0, 0, 0, 0, 0);
        chk("ovr_idle_held", ovr_o, 1'b1);

        // Reset in the middle of a frame, then a clean restart
        cyc(1, 15'h0009, 8'd1, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 32'h1000 + i);
        do_reset(3);
        cyc(0, 0, 0, 0, 0);

        // Seed 1, N=1, 109 back-to-back pulses of zero data
        cyc(1, 15'h0001, 8'd1, 0, 0);
        chk("ovr_cleared", ovr_o, 1'b0);
        for (int i = 0; i < 109; i++) cyc(0, 0, 0, 1, 32'h0);
        cyc(0, 0, 0, 0, 0);
        chk("seed1_pn_hi", {49'd0, cap_pn17[31:17]}, 64'h3);
        chk("seed1_pn0",   cap_pn17, 32'h0006_0014);
        chk("seed1_done",  done_at, 109);
        chk("seed1_count", out_cnt, 109);

        // N=0: header-only frame, then one surplus pulse
        cyc(1, 15'h1234, 8'd0, 1, 32'ha5a5_0000);
        for (int i = 1; i < 16; i++) cyc(0, 0, 0, 1, 32'ha5a5_0000 + i);
        cyc(0, 0, 0, 1, 32'hffff_ffff);
        cyc(0, 0, 0, 0, 0);
        chk("n0_done",  done_at, 16);
        chk("n0_count", out_cnt, 16);
        chk("n0_ovr",   ovr_o, 1'b1);

        // N=2 with random gaps across the block boundary
        cyc(1, 15'h2b6d, 8'd2, 0, 0);
        for (int i = 0; i < 202; i++) begin
            repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 0, 0);
            cyc(0, 0, 0, 1, $urandom);
        end
        cyc(0, 0, 0, 0, 0);
        chk("n2_done",  done_at, 202);
        chk("n2_count", out_cnt, 202);

        // Zero-seed restart coinciding with a pulse in the middle of DATA
        cyc(1, 15'h0777, 8'd1, 0, 0);
        for (int i = 0; i < 26; i++) cyc(0, 0, 0, 1, 32'h5000 + i);
        cyc(1, 15'h0000, 8'd1, 1, 32'hcafe_0000);
        for (int i = 1; i < 20; i++) cyc(0, 0, 0, 1, 32'hcafe_0000 + i);
        cyc(0, 0, 0, 0, 0);
        chk("seed0_pn0",   cap_pn17, 32'h0006_0014);
        chk("seed0_count", out_cnt, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
